// File: rtl/axi_ddr3_memtest.sv
// AXI4 write/read-back memory tester: writes an LFSR pattern over a burst range, reads it back
// and counts mismatches. Define MEMTEST_HALT_ON_FAIL_EN to stop after the first failing burst.
module axi_ddr3_memtest #(
  parameter int unsigned ADDR_BITS = 23,
  parameter int unsigned REQID     = 4,
  parameter int unsigned BURSTS    = 256,
  parameter int unsigned BASE      = 0,
  parameter logic [31:0] SEED      = 32'h1,
  parameter int unsigned ID_W      = 1,
  parameter int unsigned ID_R      = 2
) (
  input  logic                 clock,
  input  logic                 reset_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [15:0]          err_count_o,
  output logic [ADDR_BITS-1:0] fail_addr_o,
  output logic                 axi_awvalid_o,
  input  logic                 axi_awready_i,
  output logic [ADDR_BITS-1:0] axi_awaddr_o,
  output logic [REQID-1:0]     axi_awid_o,
  output logic [7:0]           axi_awlen_o,
  output logic [1:0]           axi_awburst_o,
  output logic                 axi_wvalid_o,
  input  logic                 axi_wready_i,
  output logic                 axi_wlast_o,
  output logic [3:0]           axi_wstrb_o,
  output logic [31:0]          axi_wdata_o,
  input  logic                 axi_bvalid_i,
  output logic                 axi_bready_o,
  input  logic [1:0]           axi_bresp_i,
  input  logic [REQID-1:0]     axi_bid_i,
  output logic                 axi_arvalid_o,
  input  logic                 axi_arready_i,
  output logic [ADDR_BITS-1:0] axi_araddr_o,
  output logic [REQID-1:0]     axi_arid_o,
  output logic [7:0]           axi_arlen_o,
  output logic [1:0]           axi_arburst_o,
  input  logic                 axi_rvalid_i,
  output logic                 axi_rready_o,
  input  logic                 axi_rlast_i,
  input  logic [1:0]           axi_rresp_i,
  input  logic [REQID-1:0]     axi_rid_i,
  input  logic [31:0]          axi_rdata_i
);

  localparam logic [31:0]          Poly      = 32'h8020_0003;
  localparam logic [31:0]          SeedEff   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [ADDR_BITS-1:0] BaseAddr  = ADDR_BITS'(BASE);
  localparam logic [ADDR_BITS-1:0] AddrOne   = ADDR_BITS'(1);
  localparam int unsigned          CntW      = ADDR_BITS + 1;
  localparam logic [CntW-1:0]      LastBurst = CntW'(BURSTS - 1);
  localparam logic [CntW-1:0]      CntOne    = CntW'(1);
  localparam logic [REQID-1:0]     IdW       = REQID'(ID_W);
  localparam logic [REQID-1:0]     IdR       = REQID'(ID_R);
`ifdef MEMTEST_HALT_ON_FAIL_EN
  localparam bit HaltOnFail = 1'b1;
`else
  localparam bit HaltOnFail = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData, StDone
  } state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? Poly : 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_step4(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    for (int i = 0; i < 4; i++) t = lfsr_step(t);
    return t;
  endfunction

  state_e                 r_state, w_state_next;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [CntW-1:0]        r_burst;
  logic [2:0]             r_beat;
  logic [31:0]            r_lfsr, r_burst_lfsr;
  logic [15:0]            r_err_count;
  logic [ADDR_BITS-1:0]   r_fail_addr;

  logic        w_start, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic        w_last_burst, w_any_err, w_halt;
  logic [31:0] w_lfsr_next, w_lfsr_bound;
  logic [2:0]  w_err_inc;
  logic [16:0] w_err_sum;
  logic [15:0] w_err_count_next;

  assign w_start      = start_i && (r_state == StIdle || r_state == StDone);
  assign w_aw_hs      = axi_awvalid_o && axi_awready_i;
  assign w_w_hs       = axi_wvalid_o && axi_wready_i;
  assign w_b_hs       = axi_bready_o && axi_bvalid_i;
  assign w_ar_hs      = axi_arvalid_o && axi_arready_i;
  assign w_r_hs       = axi_rready_o && axi_rvalid_i;
  assign w_last_burst = (r_burst == LastBurst);
  assign w_lfsr_next  = lfsr_step(r_lfsr);
  // Burst boundary: an early rlast must not shift the pattern of later bursts.
  assign w_lfsr_bound = lfsr_step4(r_burst_lfsr);

  always_comb begin
    w_err_inc = 3'd0;
    if (w_b_hs) begin
      w_err_inc = {2'b00, (axi_bresp_i != 2'b00) || (axi_bid_i != IdW)};
    end else if (w_r_hs) begin
      w_err_inc = 3'({2'b00, axi_rdata_i != w_lfsr_next}) +
                  3'({2'b00, axi_rresp_i != 2'b00}) +
                  3'({2'b00, axi_rid_i != IdR}) +
                  3'({2'b00, axi_rlast_i != (r_beat == 3'd3)});
    end
  end

  assign w_err_sum        = {1'b0, r_err_count} + {14'd0, w_err_inc};
  assign w_err_count_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  assign w_any_err        = (r_err_count != 16'd0) || (w_err_inc != 3'd0);
  assign w_halt           = HaltOnFail && w_any_err;

  always_ff @(posedge clock) begin
    if (!reset_ni) r_state <= StIdle;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (start_i) w_state_next = StWrAddr;
      StWrAddr:       if (axi_awready_i) w_state_next = StWrData;
      StWrData:       if (axi_wready_i && r_beat == 3'd3) w_state_next = StWrResp;
      StWrResp: begin
        if (axi_bvalid_i) begin
          if (w_halt)            w_state_next = StDone;
          else if (w_last_burst) w_state_next = StRdAddr;
          else                   w_state_next = StWrAddr;
        end
      end
      StRdAddr:       if (axi_arready_i) w_state_next = StRdData;
      StRdData: begin
        if (axi_rvalid_i && axi_rlast_i) begin
          if (w_halt || w_last_burst) w_state_next = StDone;
          else                        w_state_next = StRdAddr;
        end
      end
      default:        w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy_o        = (r_state != StIdle) && (r_state != StDone);
    done_o        = (r_state == StDone);
    pass_o        = done_o && (r_err_count == 16'd0);
    err_count_o   = r_err_count;
    fail_addr_o   = r_fail_addr;
    axi_awvalid_o = (r_state == StWrAddr);
    axi_wvalid_o  = (r_state == StWrData);
    axi_bready_o  = (r_state == StWrResp);
    axi_arvalid_o = (r_state == StRdAddr);
    axi_rready_o  = (r_state == StRdData);
    axi_awlen_o   = 8'd3;
    axi_arlen_o   = 8'd3;
    axi_awaddr_o  = axi_awvalid_o ? r_addr : '0;
    axi_awid_o    = axi_awvalid_o ? IdW : '0;
    axi_awburst_o = axi_awvalid_o ? 2'b01 : 2'b00;
    axi_araddr_o  = axi_arvalid_o ? r_addr : '0;
    axi_arid_o    = axi_arvalid_o ? IdR : '0;
    axi_arburst_o = axi_arvalid_o ? 2'b01 : 2'b00;
    axi_wdata_o   = axi_wvalid_o ? w_lfsr_next : 32'h0;
    axi_wstrb_o   = axi_wvalid_o ? 4'hF : 4'h0;
    axi_wlast_o   = axi_wvalid_o && (r_beat == 3'd3);
  end

  always_ff @(posedge clock) begin
    if (!reset_ni) begin
      r_addr       <= '0;
      r_burst      <= '0;
      r_beat       <= 3'd0;
      r_lfsr       <= SeedEff;
      r_burst_lfsr <= SeedEff;
      r_err_count  <= 16'd0;
      r_fail_addr  <= '0;
    end else if (w_start) begin
      r_addr       <= BaseAddr;
      r_burst      <= '0;
      r_beat       <= 3'd0;
      r_lfsr       <= SeedEff;
      r_burst_lfsr <= SeedEff;
      r_err_count  <= 16'd0;
      r_fail_addr  <= '0;
    end else begin
      if (w_aw_hs || w_ar_hs) r_beat <= 3'd0;
      if (w_w_hs) begin
        r_lfsr <= w_lfsr_next;
        r_beat <= r_beat + 3'd1;
      end
      if (w_b_hs) begin
        if (w_last_burst) begin
          r_addr       <= BaseAddr;
          r_burst      <= '0;
          r_lfsr       <= SeedEff;
          r_burst_lfsr <= SeedEff;
        end else begin
          r_addr  <= r_addr + AddrOne;
          r_burst <= r_burst + CntOne;
        end
      end
      if (w_r_hs) begin
        if (axi_rlast_i) begin
          r_lfsr       <= w_lfsr_bound;
          r_burst_lfsr <= w_lfsr_bound;
          r_addr       <= r_addr + AddrOne;
          r_burst      <= r_burst + CntOne;
        end else begin
          r_lfsr <= w_lfsr_next;
          if (r_beat != 3'd7) r_beat <= r_beat + 3'd1;
        end
      end
      if (w_err_inc != 3'd0) begin
        r_err_count <= w_err_count_next;
        if (r_err_count == 16'd0) r_fail_addr <= r_addr;
      end
    end
  end

endmodule
